mem8x8_ctrl: RTL

Sequencing controller for the 8x8 latch-based memory array, which is 8 rows of 8 bitcells. Each bitcell has complementary write enables (we/wen) and read enables (re/ren). The block accepts single-word read and write requests from a host over a ready/req handshake. It latches address and data, then drives one-hot, non-overlapping row enable pulses with a setup and hold cycle around each pulse. Read data is captured from the array output bus and returned with a one-cycle rvalid strobe.

---
 rtl/mem8x8_pkg.sv | 18 +
 rtl/mem8x8_if.sv | 23 ++
 rtl/mem8x8_row_dec.sv | 17 +
 rtl/mem8x8_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mem8x8_pkg.sv
// Shared dimensions and state encoding for the 8x8 latch-array sequencer.
package mem8x8_pkg;

    localparam int ROWS   = 8;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_WPULSE = 3'd2,
        S_HOLD   = 3'd3,
        S_RPULSE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/mem8x8_if.sv
// Host-side request/response bundle for the 8x8 array sequencer.
interface mem8x8_if;
    import mem8x8_pkg::*;

    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic              ready;
    logic [WIDTH-1:0]  rdata;
    logic              rvalid;

    modport master (
        output req, wr, addr, wdata,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  req, wr, addr, wdata,
        output ready, rdata, rvalid
    );

endinterface

// File: rtl/mem8x8_row_dec.sv
// 3-to-8 one-hot row decoder; all outputs low when en is low.
module mem8x8_row_dec
    import mem8x8_pkg::*;
(
    input  logic              en,
    input  logic [ADDR_W-1:0] sel,
    output logic [ROWS-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/mem8x8_ctrl.sv
// Sequencer for the 8x8 latch array: host handshake in, non-overlapping row pulses out.
// state  | meaning
// IDLE   | ready high, waiting for req
// SETUP  | operands latched, din settling before the pulse
// WPULSE | row write enable high for WE_CYCLES
// HOLD   | enables off, din held after the write pulse
// RPULSE | row read enable high for RE_CYCLES
// DONE   | rvalid strobe
module mem8x8_ctrl
    import mem8x8_pkg::*;
#(
    parameter int unsigned WE_CYCLES = 1,
    parameter int unsigned RE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    mem8x8_if.slave          host,
    output logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] dout,
    output logic [ROWS-1:0]  row_we,
    output logic [ROWS-1:0]  row_wen,
    output logic [ROWS-1:0]  row_re,
    output logic [ROWS-1:0]  row_ren
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  din_q, din_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic              we_en_q, we_en_d;
    logic              re_en_q, re_en_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            we_en_q  <= 1'b0;
            re_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            we_en_q  <= we_en_d;
            re_en_q  <= re_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (host.req) begin
                    state_d = S_SETUP;
                    wr_d    = host.wr;
                    addr_d  = host.addr;
                end
            end
            S_SETUP: begin
                state_d = wr_q ? S_WPULSE : S_RPULSE;
                cnt_d   = wr_q ? CNT_W'(WE_CYCLES) : CNT_W'(RE_CYCLES);
            end
            S_WPULSE: begin
                if (cnt_q <= 8'd1) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HOLD: state_d = S_IDLE;
            S_RPULSE: begin
                if (cnt_q <= 8'd1) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Everything below is keyed off state_d so each output flop lines up with state_q.
    always_comb begin
        ready_d  = (state_d == S_IDLE);
        rvalid_d = (state_d == S_DONE);
        we_en_d  = (state_d == S_WPULSE);
        re_en_d  = (state_d == S_RPULSE);
        din_d    = din_q;
        rdata_d  = rdata_q;
        if (state_q == S_IDLE && host.req && host.wr) begin
            din_d = host.wdata;
        end
        if (state_q == S_RPULSE && state_d == S_DONE) begin
            rdata_d = dout;
        end
    end

    mem8x8_row_dec u_we_dec (
        .en     (we_en_q),
        .sel    (addr_q),
        .onehot (row_we)
    );

    mem8x8_row_dec u_re_dec (
        .en     (re_en_q),
        .sel    (addr_q),
        .onehot (row_re)
    );

    assign row_wen     = ~row_we;
    assign row_ren     = ~row_re;
    assign din         = din_q;
    assign host.ready  = ready_q;
    assign host.rdata  = rdata_q;
    assign host.rvalid = rvalid_q;

endmodule
